// File: rtl/seg_mux_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_mux_display
// Description : Multiplexed seven-segment driver with frame-synchronous
//               double-buffered loading, per-digit blanking, decimal points
//               and 16-level PWM brightness. Optional leading-zero blanking
//               is enabled by defining LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_mux_display #(
    parameter int DIGITS         = 4,
    parameter int DIV_WIDTH      = 12,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic [3:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     en,
    output logic                  frame_done
);

    localparam int                  c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]          c_SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                c_DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0]   c_EN_OFF   = {DIGITS{EN_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Prescaler and digit scan
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 w_tick;
    logic                 w_wrap;

    assign w_tick = &r_cnt;
    assign w_wrap = w_tick && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-buffered display contents
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_blank;
    logic                r_pend_valid;
    logic [4*DIGITS-1:0] r_act_data;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blank;

    // A load coincident with the wrap still commits the previous pending
    // value; the new one waits in pending for the following wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
        end else begin
            if (w_wrap && r_pend_valid) begin
                r_act_data   <= r_pend_data;
                r_act_dp     <= r_pend_dp;
                r_act_blank  <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] w_lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_run[k] is set when nibbles k..DIGITS-1 are all zero
    logic [DIGITS:1] w_zero_run;

    assign w_zero_run[DIGITS] = 1'b1;
    assign w_lz_blank[0]      = 1'b0;

    for (genvar k = 1; k < DIGITS; k++) begin : g_lz
        assign w_zero_run[k] = w_zero_run[k+1] & (r_act_data[4*k +: 4] == 4'h0);
        assign w_lz_blank[k] = w_zero_run[k];
    end
`else
    assign w_lz_blank = '0;
`endif

    // ------------------------------------------------------------------
    // Selected digit, decode and PWM gating
    // ------------------------------------------------------------------
    logic [3:0]        w_nib;
    logic              w_dp_sel;
    logic              w_dark;
    logic [6:0]        w_seg_dec;
    logic              w_lit;
    logic              w_sel;
    logic [DIGITS-1:0] w_en_nxt;

    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_dark   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_nib    = r_act_data[4*k +: 4];
                w_dp_sel = r_act_dp[k];
                w_dark   = r_act_blank[k] | w_lz_blank[k];
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'b0000000;
        case (w_nib)
            4'h0: w_seg_dec = 7'b1111110;
            4'h1: w_seg_dec = 7'b0110000;
            4'h2: w_seg_dec = 7'b1101101;
            4'h3: w_seg_dec = 7'b1111001;
            4'h4: w_seg_dec = 7'b0110011;
            4'h5: w_seg_dec = 7'b1011011;
            4'h6: w_seg_dec = 7'b1011111;
            4'h7: w_seg_dec = 7'b1110000;
            4'h8: w_seg_dec = 7'b1111111;
            4'h9: w_seg_dec = 7'b1111011;
            4'hA: w_seg_dec = 7'b1110111;
            4'hB: w_seg_dec = 7'b0011111;
            4'hC: w_seg_dec = 7'b1001110;
            4'hD: w_seg_dec = 7'b0111101;
            4'hE: w_seg_dec = 7'b1001111;
            4'hF: w_seg_dec = 7'b1000111;
            default: w_seg_dec = 7'b0000000;
        endcase
    end

    // Duty cycle comes from the top nibble of the prescaler within a slot
    assign w_lit = (r_cnt[DIV_WIDTH-1 -: 4] < bright);
    assign w_sel = w_lit & ~w_dark;

    always_comb begin
        w_en_nxt = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_en_nxt[k] = w_sel && (r_idx == c_IDX_W'(k));
        end
    end

    // ------------------------------------------------------------------
    // Output registers with polarity applied
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] r_en;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en         <= c_EN_OFF;
            r_seg        <= c_SEG_OFF;
            r_dp         <= c_DP_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_en         <= w_en_nxt ^ c_EN_OFF;
            r_seg        <= (w_sel ? w_seg_dec : 7'b0000000) ^ c_SEG_OFF;
            r_dp         <= (w_sel & w_dp_sel) ^ c_DP_OFF;
            r_frame_done <= w_wrap;
        end
    end

    assign en         = r_en;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_mux_display
// Description : Self-checking bench for seg_mux_display (DIGITS=4,
//               DIV_WIDTH=4, active-high outputs); honours LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_mux_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  en;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_mux_display #(
        .DIGITS         (4),
        .DIV_WIDTH      (4),
        .SEG_ACTIVE_LOW (1'b0),
        .EN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .en         (en),
        .frame_done (frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elapsed cycles since reset plus the two buffers
    int          m_c;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_act_blank, m_pend_dp, m_pend_blank;
    logic        m_pv;
    int          m_time;

    logic [6:0] font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    int         on_cnt   [4];
    int         dp_cnt   [4];
    logic [6:0] seg_seen [4];

    function automatic logic m_dark(int k);
        logic d;
        d = m_act_blank[k];
`ifdef LEADING_ZERO_BLANK_EN
        if (k != 0 && (m_act >> (4*k)) == 16'h0) d = 1'b1;
`endif
        return d;
    endfunction

    task automatic step();
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp, e_fd, wrap;
        int         cnt, idx;
        e_en = 4'b0; e_seg = 7'b0; e_dp = 1'b0; e_fd = 1'b0; wrap = 1'b0;
        if (!rst) begin
            cnt  = m_c % 16;
            idx  = (m_c / 16) % 4;
            wrap = ((m_c % 64) == 63);
            if (cnt < int'(bright) && !m_dark(idx)) begin
                e_en  = 4'(1 << idx);
                e_seg = font[m_act[4*idx +: 4]];
                e_dp  = m_act_dp[idx];
            end
            e_fd = wrap;
        end
        @(posedge clk);
        #1;
        m_time++;
        n_vec++;
        if ({en, seg, dp, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
            n_err++;
            $display("FAIL cycle %0d: en=%b seg=%b dp=%b fd=%b, expected en=%b seg=%b dp=%b fd=%b",
                     m_time, en, seg, dp, frame_done, e_en, e_seg, e_dp, e_fd);
        end
        for (int k = 0; k < 4; k++) begin
            if (en[k] === 1'b1) begin
                on_cnt[k]++;
                seg_seen[k] = seg;
                if (dp === 1'b1) dp_cnt[k]++;
            end
        end
        if (rst) begin
            m_c = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_act_blank = '0;
            m_pend_dp = '0; m_pend_blank = '0; m_pv = 1'b0;
        end else begin
            if (wrap && m_pv) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                m_pv = 1'b0;
            end
            if (load) begin
                m_pend = data; m_pend_dp = dp_in; m_pend_blank = blank_in;
                m_pv = 1'b1;
            end
            m_c++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        data = d; dp_in = dpv; blank_in = bl; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic align(input int phase);
        int guard;
        guard = 0;
        while ((m_c % 64) != phase) begin
            step();
            guard++;
            if (guard > 200) begin
                n_err++;
                $display("FAIL align: phase %0d not reached, at %0d", phase, m_c % 64);
                break;
            end
        end
    endtask

    task automatic wait_commit();
        int guard;
        guard = 0;
        while (m_pv || (m_c % 64) != 0) begin
            step();
            guard++;
            if (guard > 300) begin
                n_err++;
                $display("FAIL commit: pending not committed, pv=%0b", m_pv);
                break;
            end
        end
    endtask

    task automatic run_frame();
        for (int k = 0; k < 4; k++) begin
            on_cnt[k] = 0; dp_cnt[k] = 0; seg_seen[k] = 7'b0;
        end
        repeat (64) step();
    endtask

    task automatic check_frame(input logic [27:0] segs, input logic [3:0] on,
                               input logic [3:0] dpv, input logic [3:0] br, input string tag);
        int exp_on, exp_dp;
        for (int k = 0; k < 4; k++) begin
            exp_on = on[k] ? int'(br) : 0;
            exp_dp = (on[k] && dpv[k]) ? int'(br) : 0;
            n_vec++;
            if (on_cnt[k] != exp_on) begin
                n_err++;
                $display("FAIL %s on_count[%0d]: got %0d, expected %0d", tag, k, on_cnt[k], exp_on);
            end
            n_vec++;
            if (dp_cnt[k] != exp_dp) begin
                n_err++;
                $display("FAIL %s dp_count[%0d]: got %0d, expected %0d", tag, k, dp_cnt[k], exp_dp);
            end
            if (exp_on != 0) begin
                n_vec++;
                if (seg_seen[k] !== segs[7*k +: 7]) begin
                    n_err++;
                    $display("FAIL %s seg[%0d]: got %b, expected %b", tag, k, seg_seen[k], segs[7*k +: 7]);
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  on;
        logic [3:0]  on_lz;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          fd_t [$];
        logic [3:0]  on_sel;

        tbl[0] = '{16'h8F31, 4'b0000, 4'b0000, 4'd15,
                   {7'b1111111, 7'b1000111, 7'b1111001, 7'b0110000}, 4'b1111, 4'b1111};
        tbl[1] = '{16'h0070, 4'b0000, 4'b0000, 4'd8,
                   {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110}, 4'b1111, 4'b0011};
        tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 4'd8,
                   {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b1111, 4'b0001};
        tbl[3] = '{16'h4567, 4'b0001, 4'b0100, 4'd15,
                   {7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000}, 4'b1011, 4'b1011};
        tbl[4] = '{16'hEDCB, 4'b1010, 4'b0000, 4'd3,
                   {7'b1001111, 7'b0111101, 7'b1001110, 7'b0011111}, 4'b1111, 4'b1111};
        tbl[5] = '{16'h2A90, 4'b1111, 4'b0000, 4'd0,
                   {7'b1101101, 7'b1110111, 7'b1111011, 7'b1111110}, 4'b0000, 4'b0000};
        tbl[6] = '{16'h0A92, 4'b0100, 4'b0000, 4'd1,
                   {7'b1111110, 7'b1110111, 7'b1111011, 7'b1101101}, 4'b1111, 4'b0111};

        m_c = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_act_blank = '0;
        m_pend_dp = '0; m_pend_blank = '0; m_pv = 1'b0; m_time = 0;
        rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; blank_in = '0; bright = 4'd15;
        step();
        step();
        rst = 1'b0;

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            bright = tbl[i].bright;
            do_load(tbl[i].data, tbl[i].dp, tbl[i].blank);
            wait_commit();
            run_frame();
`ifdef LEADING_ZERO_BLANK_EN
            on_sel = tbl[i].on_lz;
`else
            on_sel = tbl[i].on;
`endif
            check_frame(tbl[i].segs, on_sel, tbl[i].dp, tbl[i].bright, $sformatf("tbl%0d", i));
        end

        // Three loads in one frame: last one wins
        bright = 4'd15;
        align(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        step();
        do_load(16'h2222, 4'b0000, 4'b0000);
        repeat (10) step();
        do_load(16'h3333, 4'b0000, 4'b0000);
        align(0);
        run_frame();
        check_frame({4{7'b1111001}}, 4'b1111, 4'b0000, 4'd15, "lastwins");

        // Load on the wrap tick commits one frame later
        align(63);
        do_load(16'h5555, 4'b0000, 4'b0000);
        run_frame();
        check_frame({4{7'b1111001}}, 4'b1111, 4'b0000, 4'd15, "wrapload_hold");
        run_frame();
        check_frame({4{7'b1011011}}, 4'b1111, 4'b0000, 4'd15, "wrapload_commit");

        // Reset mid-slot discards pending
        align(20);
        do_load(16'h6666, 4'b0000, 4'b0000);
        repeat (5) step();
        rst = 1'b1;
        step();
        n_vec++;
        if ({en, seg, dp, frame_done} !== 12'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, expected %b", {en, seg, dp, frame_done}, 12'b0);
        end
        rst = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        on_sel = 4'b0001;
`else
        on_sel = 4'b1111;
`endif
        run_frame();
        check_frame({4{7'b1111110}}, on_sel, 4'b0000, 4'd15, "post_reset0");
        run_frame();
        check_frame({4{7'b1111110}}, on_sel, 4'b0000, 4'd15, "post_reset1");

        // frame_done period
        for (int t = 0; t < 200; t++) begin
            step();
            if (frame_done === 1'b1) fd_t.push_back(t);
        end
        n_vec++;
        if (fd_t.size() < 3) begin
            n_err++;
            $display("FAIL fd_count: got %0d pulses, expected at least 3", fd_t.size());
        end
        for (int i = 1; i < fd_t.size(); i++) begin
            n_vec++;
            if (fd_t[i] - fd_t[i-1] != 64) begin
                n_err++;
                $display("FAIL fd_period: got %0d, expected 64", fd_t[i] - fd_t[i-1]);
            end
        end

        // Randomized traffic against the model
        for (int t = 0; t < 4000; t++) begin
            load = ($urandom_range(0, 19) == 0);
            data = 16'($urandom);
            dp_in = 4'($urandom);
            blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
